// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, stage-control
// bundle and the handful of control patterns the sequencer can emit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    IWAIT = 2'd2,
    DWAIT = 2'd3
  } state_t;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  typedef struct packed {
    logic if_rst;
    logic if_en;
    logic id_rst;
    logic id_en;
    logic exe_rst;
    logic exe_en;
    logic mem_rst;
    logic mem_en;
    logic wb_rst;
    logic wb_en;
  } stage_ctrl_t;

  // Whole-pipeline reset, full freeze, free flow.
  localparam stage_ctrl_t CTRL_RESET  = 10'b10_10_10_10_10;
  localparam stage_ctrl_t CTRL_FREEZE = 10'b00_00_00_00_00;
  localparam stage_ctrl_t CTRL_FLOW   = 10'b01_01_01_01_01;
  // PC loads branch target, wrong-path ID instruction is squashed.
  localparam stage_ctrl_t CTRL_TARGET = 10'b01_10_01_01_01;
  // IF/ID hold, bubble enters EXE.
  localparam stage_ctrl_t CTRL_BUBBLE = 10'b00_00_10_01_01;
  // PC holds, ID squashed, downstream drains.
  localparam stage_ctrl_t CTRL_FLUSH  = 10'b00_10_01_01_01;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW detector: the ID instruction reads a register that an
// older in-flight instruction has yet to write. $0 never hazards.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_HAZARD = 1
) (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       rs_used,
  input  logic       rt_used,
  input  logic       id_valid,
  input  logic [4:0] regw_addr_exe,
  input  logic [4:0] regw_addr_mem,
  input  logic [4:0] regw_addr_wb,
  input  logic       wb_wen_exe,
  input  logic       wb_wen_mem,
  input  logic       wb_wen_wb,
  output logic       raw
);

  function automatic logic pending_write(input logic [4:0] src,
                                         input logic [4:0] a_exe, input logic w_exe,
                                         input logic [4:0] a_mem, input logic w_mem,
                                         input logic [4:0] a_wb,  input logic w_wb);
    logic hit;
    hit = (w_exe && a_exe == src) || (w_mem && a_mem == src);
    if (WB_HAZARD != 0) hit = hit || (w_wb && a_wb == src);
    return hit;
  endfunction

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = rs_used && rs != GPR_ZERO &&
             pending_write(rs, regw_addr_exe, wb_wen_exe, regw_addr_mem, wb_wen_mem,
                           regw_addr_wb, wb_wen_wb);
    rt_hit = rt_used && rt != GPR_ZERO &&
             pending_write(rt, regw_addr_exe, wb_wen_exe, regw_addr_mem, wb_wen_mem,
                           regw_addr_wb, wb_wen_wb);
    raw    = id_valid && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS datapath: drives per-stage rst/en.
// Optional perf counters (cycle_cnt, stall_cnt, flush_cnt) with PIPE_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int WB_HAZARD   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data_id,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic        id_valid,
  input  logic        branch_id,
  input  logic        is_branch_exe,
  input  logic        is_branch_mem,
  input  logic [4:0]  regw_addr_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic [4:0]  regw_addr_wb,
  input  logic        wb_wen_exe,
  input  logic        wb_wen_mem,
  input  logic        wb_wen_wb,
  input  logic        inst_ren,
  input  logic        inst_ack,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        mem_ack,
  output logic        if_rst,
  output logic        if_en,
  output logic        id_rst,
  output logic        id_en,
  output logic        exe_rst,
  output logic        exe_en,
  output logic        mem_rst,
  output logic        mem_en,
  output logic        wb_rst,
  output logic        wb_en,
  output logic        timeout_err,
  output state_t      state
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int INIT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  state_t            next_state;
  state_t            run_next;
  stage_ctrl_t       run_ctrl;
  stage_ctrl_t       ctrl;
  logic              raw;
  logic              mem_busy;
  logic              run_iack;
  logic              timeout_hit;
  logic              unused_inst_bits;

  assign unused_inst_bits = ^{inst_data_id[31:26], inst_data_id[15:0]};

  pipe_hazard_detect #(.WB_HAZARD(WB_HAZARD)) u_hazard (
    .rs            (inst_data_id[25:21]),
    .rt            (inst_data_id[20:16]),
    .rs_used       (rs_used_id),
    .rt_used       (rt_used_id),
    .id_valid      (id_valid),
    .regw_addr_exe (regw_addr_exe),
    .regw_addr_mem (regw_addr_mem),
    .regw_addr_wb  (regw_addr_wb),
    .wb_wen_exe    (wb_wen_exe),
    .wb_wen_mem    (wb_wen_mem),
    .wb_wen_wb     (wb_wen_wb),
    .raw           (raw)
  );

  // The MEM-wait term is ignored while already in DWAIT; IWAIT only consults
  // the RUN rules once the fetch is resolved, so the fetch counts as acked.
  assign mem_busy    = (mem_ren || mem_wen) && !mem_ack && state != DWAIT;
  assign run_iack    = inst_ack || state == IWAIT;
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout_hit = (state == IWAIT || state == DWAIT) &&
                       wait_cnt == WAIT_W'(MEM_TIMEOUT - 1);

  always_comb begin
    run_ctrl = CTRL_FLOW;
    run_next = RUN;
    if (mem_busy) begin
      run_ctrl = CTRL_FREEZE;
      run_next = DWAIT;
    end else if (is_branch_mem) begin
      run_ctrl = CTRL_TARGET;
    end else if (raw) begin
      run_ctrl = CTRL_BUBBLE;
    end else if (branch_id || is_branch_exe) begin
      run_ctrl = CTRL_FLUSH;
    end else if (inst_ren && !run_iack) begin
      run_ctrl = CTRL_FLUSH;
      run_next = IWAIT;
    end
  end

  always_comb begin
    ctrl       = CTRL_RESET;
    next_state = state;
    case (state)
      INIT: if (init_cnt == INIT_W'(RST_CYCLES - 1)) next_state = RUN;
      RUN: begin
        ctrl       = run_ctrl;
        next_state = run_next;
      end
      DWAIT: begin
        if (mem_ack || timeout_hit) begin
          ctrl       = run_ctrl;
          next_state = RUN;
        end else begin
          ctrl = CTRL_FREEZE;
        end
      end
      IWAIT: begin
        if (is_branch_mem || inst_ack || timeout_hit) begin
          ctrl       = run_ctrl;
          next_state = run_next;
        end else if (raw) begin
          ctrl = CTRL_BUBBLE;
        end else begin
          ctrl = CTRL_FLUSH;
        end
      end
      default: next_state = INIT;
    endcase
  end

  assign if_rst  = ctrl.if_rst;
  assign if_en   = ctrl.if_en;
  assign id_rst  = ctrl.id_rst;
  assign id_en   = ctrl.id_en;
  assign exe_rst = ctrl.exe_rst;
  assign exe_en  = ctrl.exe_en;
  assign mem_rst = ctrl.mem_rst;
  assign mem_en  = ctrl.mem_en;
  assign wb_rst  = ctrl.wb_rst;
  assign wb_en   = ctrl.wb_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= next_state;
      init_cnt <= (state == INIT) ? init_cnt + 1'b1 : '0;
      wait_cnt <= ((state == IWAIT || state == DWAIT) && next_state == state) ?
                  wait_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != INIT) cycle_cnt <= cycle_cnt + 32'd1;
      if (!if_en) stall_cnt <= stall_cnt + 32'd1;
      if (id_rst && state != INIT) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
